// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the scoreboarded register file.
// No logic; constants only.
// No flow control.
package regfile_sb_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;

  // Index of the hardwired-zero register.
  localparam int ZERO_REG     = 0;

endpackage

// File: rtl/regfile_sb_reg_word.sv
// One WIDTH-bit architectural register with write enable.
// Latency: d appears on q one rising edge after en.
// No backpressure; asynchronous active-low clear.
module reg_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold value; load on enable; clear immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, write bypass and protocol error flag.
// Latency: reads/ready/err combinational; writes and busy updates take effect at next edge.
// No backpressure: err only flags misuse, state always updates.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  // NUM_REGS must equal 2**ADDR_W so every address decodes to a real register.
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [WIDTH-1:0]  rd1_data,
  output logic [WIDTH-1:0]  rd2_data,
  output logic              rd1_ready,
  output logic              rd2_ready,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;

  // Writes and issues aimed at the zero register are ignored everywhere.
  logic wr_live;
  logic issue_live;
  assign wr_live    = wr_en    && (wr_addr    != ZERO_ADDR);
  assign issue_live = issue_en && (issue_addr != ZERO_ADDR);

  // Register 0 has no storage; it always reads zero.
  assign regs[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    logic wr_sel;
    assign wr_sel = wr_en && (wr_addr == ADDR_W'(i));

    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .en  (wr_sel),
      .d   (wr_data),
      .q   (regs[i])
    );
  end

  // Busy next state: writeback clears, issue sets, and issue wins on a same-address collision.
  always_comb begin
    busy_nxt = busy_q;
    if (wr_live) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (issue_live) begin
      busy_nxt[issue_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy bits; reset drops all pending producers at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  // Read ports: a same-cycle writeback is forwarded and also makes the operand ready.
  // Issue in the same cycle is deliberately not looked at here.
  always_comb begin
    logic rd1_byp;
    logic rd2_byp;
    rd1_byp   = wr_live && (wr_addr == rd1_addr);
    rd2_byp   = wr_live && (wr_addr == rd2_addr);
    rd1_data  = rd1_byp ? wr_data : regs[rd1_addr];
    rd2_data  = rd2_byp ? wr_data : regs[rd2_addr];
    rd1_ready = !busy_q[rd1_addr] || rd1_byp;
    rd2_ready = !busy_q[rd2_addr] || rd2_byp;
  end

  // Error flag: unknown control/address, double issue, or writeback with no issued producer.
  always_comb begin
    logic x_err;
    logic dbl_issue;
    logic orphan_wb;
    x_err     = $isunknown({wr_en, issue_en, wr_addr, issue_addr, rd1_addr, rd2_addr});
    dbl_issue = issue_live && busy_q[issue_addr] && !(wr_live && (wr_addr == issue_addr));
    orphan_wb = wr_live && !busy_q[wr_addr];
    err       = x_err || dbl_issue || orphan_wb;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [4:0]  rd1_addr;
  logic [4:0]  rd2_addr;
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;
  logic        rd1_ready;
  logic        rd2_ready;
  logic        err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] d1;
    logic        r1;
    logic [31:0] d2;
    logic        r2;
    logic        e;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [32];

  regfile_sb dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd1_addr   (rd1_addr),
    .rd2_addr   (rd2_addr),
    .rd1_data   (rd1_data),
    .rd2_data   (rd2_data),
    .rd1_ready  (rd1_ready),
    .rd2_ready  (rd2_ready),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia,
                       input logic [4:0] a1, input logic [4:0] a2);
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    issue_en   = ie;
    issue_addr = ia;
    rd1_addr   = a1;
    rd2_addr   = a2;
  endtask

  task automatic push(input string tag, input logic [31:0] d1, input logic r1,
                      input logic [31:0] d2, input logic r2, input logic e);
    exp_t x;
    x.tag = tag; x.d1 = d1; x.r1 = r1; x.d2 = d2; x.r2 = r2; x.e = e;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got=%0d exp=1", sb.size());
      return;
    end
    x = sb.pop_front();
    chk32({x.tag, ".rd1_data"}, rd1_data, x.d1);
    chk1 ({x.tag, ".rd1_ready"}, rd1_ready, x.r1);
    chk32({x.tag, ".rd2_data"}, rd2_data, x.d2);
    chk1 ({x.tag, ".rd2_ready"}, rd2_ready, x.r2);
    chk1 ({x.tag, ".err"}, err, x.e);
  endtask

  // Drive at the falling edge, sample 2ns later, then let one rising edge pass.
  task automatic step(input string tag,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [4:0] ia,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] d1, input logic r1,
                      input logic [31:0] d2, input logic r2, input logic e);
    drive(we, wa, wd, ie, ia, a1, a2);
    push(tag, d1, r1, d2, r2, e);
    #2;
    pop_check();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    //      tag          we wa  wd            ie ia a1 a2  d1            r1 d2            r2 e
    step("rst_idle",     0, 0,  32'h0,        0, 0, 5, 0,  32'h0,        1, 32'h0,        1, 0);
    step("rst_bypass",   1, 5,  32'hAB,       0, 0, 5, 0,  32'hAB,       1, 32'h0,        1, 1);
    step("rst_nowrite",  0, 0,  32'h0,        0, 0, 5, 0,  32'h0,        1, 32'h0,        1, 0);
    rst = 1'b1;

    step("wr_x5_byp",    1, 5,  32'hAA,       0, 0, 5, 0,  32'hAA,       1, 32'h0,        1, 1);
    step("rd_x5",        0, 0,  32'h0,        0, 0, 5, 0,  32'hAA,       1, 32'h0,        1, 0);
    step("wr_x0",        1, 0,  32'hFFFFFFFF, 0, 0, 0, 0,  32'h0,        1, 32'h0,        1, 0);
    step("rd_x0",        0, 0,  32'h0,        0, 0, 5, 0,  32'hAA,       1, 32'h0,        1, 0);

    step("iss_x7",       0, 0,  32'h0,        1, 7, 7, 5,  32'h0,        1, 32'hAA,       1, 0);
    step("x7_busy",      0, 0,  32'h0,        0, 0, 7, 5,  32'h0,        0, 32'hAA,       1, 0);
    step("wb_x7_byp",    1, 7,  32'h1234,     0, 0, 7, 7,  32'h1234,     1, 32'h1234,     1, 0);
    step("x7_clear",     0, 0,  32'h0,        0, 0, 7, 5,  32'h1234,     1, 32'hAA,       1, 0);

    step("iss_x9",       0, 0,  32'h0,        1, 9, 9, 5,  32'h0,        1, 32'hAA,       1, 0);
    step("iss_wb_x9",    1, 9,  32'h55,       1, 9, 9, 5,  32'h55,       1, 32'hAA,       1, 0);
    step("x9_set_wins",  0, 0,  32'h0,        0, 0, 9, 5,  32'h55,       0, 32'hAA,       1, 0);
    step("wb_x9",        1, 9,  32'h66,       0, 0, 9, 0,  32'h66,       1, 32'h0,        1, 0);

    step("iss_x3",       0, 0,  32'h0,        1, 3, 3, 0,  32'h0,        1, 32'h0,        1, 0);
    step("dbl_iss_x3",   0, 0,  32'h0,        1, 3, 3, 0,  32'h0,        0, 32'h0,        1, 1);
    step("orphan_wb_x4", 1, 4,  32'h1,        0, 0, 4, 0,  32'h1,        1, 32'h0,        1, 1);

    step("iss_x2",       0, 0,  32'h0,        1, 2, 2, 0,  32'h0,        1, 32'h0,        1, 0);
    step("wb_x2",        1, 2,  32'h77,       0, 0, 2, 0,  32'h77,       1, 32'h0,        1, 0);
    step("reiss_x2",     0, 0,  32'h0,        1, 2, 2, 0,  32'h77,       1, 32'h0,        1, 0);
    step("x2_x3_busy",   0, 0,  32'h0,        0, 0, 2, 3,  32'h77,       0, 32'h0,        0, 0);

    // Reset in the middle of the low phase, with no clock edge involved.
    drive(0, 0, 0, 0, 0, 2, 3);
    push("rst_mid", 32'h0, 1, 32'h0, 1, 0);
    #1;
    rst = 1'b0;
    #1;
    pop_check();
    @(negedge clk);
    rst = 1'b1;

    step("post_rst_wb",  1, 2,  32'h5,        0, 0, 2, 3,  32'h5,        1, 32'h0,        1, 1);
    step("post_rst_rd",  0, 0,  32'h0,        0, 0, 2, 7,  32'h5,        1, 32'h0,        1, 0);

    // Fill every register with a distinct pattern, then read back through both ports.
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[2] = 32'h5;
    for (int i = 1; i < 32; i++) begin
      model[i] = pat(i);
      step("fill", 1, 5'(i), pat(i), 0, 0, 5'(i), 0, pat(i), 1, 32'h0, 1, 1);
    end
    for (int i = 0; i < 32; i++) begin
      step("readback", 0, 0, 32'h0, 0, 0, 5'(i), 5'((i * 7) % 32),
           model[i], 1, model[(i * 7) % 32], 1, 0);
    end

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
